// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-addressed data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic SIZE_BYTE  = 1'b0;
    localparam logic SIZE_WORD  = 1'b1;
    localparam logic RW_READ    = 1'b0;
    localparam logic RW_WRITE   = 1'b1;
    localparam int   WORD_BEATS = 4;

endpackage

// File: rtl/mem_array_256x8.sv
// Single-port byte array: synchronous write, asynchronous read.
module mem_array_256x8 #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] Mem [2**ADDR_W];

    // Store one byte on the rising edge when enabled; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            Mem[addr] <= wdata;
        end
    end

    assign rdata = Mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder for the MEM stage: accepts one request at a time,
// serialises words into four big-endian byte beats after optional wait
// states, and returns a one-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | inserting slow-memory wait states before the first beat
// XFER  | one byte beat per edge (1 for byte, 4 for word)
// RESP  | response pulse (misaligned words spend one extra cycle here first)
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        beat_cnt;
    logic              rw_q;
    logic              size_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_sh;
    logic [31:0]       rd_sh;

    logic [ADDR_W-1:0] beat_addr;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic              last_beat;
    logic              misaligned;

    // Words are aligned, so addr_q + beat never crosses a word boundary.
    assign beat_addr  = addr_q + ADDR_W'(beat_cnt);
    assign last_beat  = (size_q == SIZE_BYTE) || (beat_cnt == 2'(WORD_BEATS - 1));
    assign misaligned = (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
    // Gating with R keeps a reset edge from landing a beat mid-transaction.
    assign mem_we     = (state == XFER) && (rw_q == RW_WRITE) && R;
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    mem_array_256x8 #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (beat_addr),
        .wdata (wd_sh[31:24]),
        .rdata (mem_rdata)
    );

    // Request FSM with wait counter, beat counter and data assembly.
    always_ff @(posedge clk) begin
        if (!R) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            rw_q       <= RW_READ;
            size_q     <= SIZE_BYTE;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wd_sh      <= '0;
            rd_sh      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rw_q     <= req_rw;
                        size_q   <= req_size;
                        addr_q   <= req_addr;
                        // Byte store data is pre-positioned in the top lane.
                        wd_sh    <= (req_size == SIZE_WORD) ? req_wdata
                                                            : {req_wdata[7:0], 24'h0};
                        rd_sh    <= '0;
                        beat_cnt <= '0;
                        err_q    <= misaligned;
                        if (misaligned) begin
                            state <= RESP;
                        end else if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES);
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    rd_sh    <= {rd_sh[23:0], mem_rdata};
                    wd_sh    <= {wd_sh[23:0], 8'h00};
                    beat_cnt <= beat_cnt + 2'd1;
                    if (last_beat) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                        resp_rdata <= (rw_q == RW_READ) ? {rd_sh[23:0], mem_rdata} : 32'h0;
                    end
                end
                RESP: begin
                    if (resp_valid) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        // Misaligned path: pulse one cycle after entering RESP.
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES 0 and 1), directed
// table, hand sequences for handshake and reset abort, random vs. model.
module tb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        R          [2];
    logic        req_valid  [2];
    logic        req_rw     [2];
    logic        req_size   [2];
    logic [7:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .R(R[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_rw(req_rw[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0])
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .R(R[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_rw(req_rw[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1])
    );

    typedef struct {
        logic        rw;
        logic        size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    int         nvec  = 0;
    int         nfail = 0;
    logic [7:0] model [2][256];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int d, input logic [7:0] a, input logic [7:0] v);
        if (d == 0) dut0.u_mem.Mem[a] = v;
        else        dut1.u_mem.Mem[a] = v;
        model[d][a] = v;
    endtask

    function automatic logic [7:0] peek(input int d, input logic [7:0] a);
        if (d == 0) return dut0.u_mem.Mem[a];
        return dut1.u_mem.Mem[a];
    endfunction

    // Reference: memory as a plain byte array, latency from the timing rules.
    task automatic model_req(input int d, input logic rw, input logic size,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat);
        int         n;
        logic [7:0] a;
        rdata = 32'h0;
        err   = 1'b0;
        if (size && addr[1:0] != 2'b00) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        n   = size ? 4 : 1;
        lat = wc(d) + n;
        if (rw) begin
            if (size) begin
                for (int i = 0; i < 4; i++) begin
                    a = addr + 8'(i);
                    model[d][a] = 8'(wdata >> (8 * (3 - i)));
                end
            end else begin
                model[d][addr] = wdata[7:0];
            end
        end else if (size) begin
            rdata = {model[d][addr], model[d][addr + 8'd1], model[d][addr + 8'd2], model[d][addr + 8'd3]};
        end else begin
            rdata = {24'h0, model[d][addr]};
        end
    endtask

    task automatic do_req(input int d, input logic rw, input logic size,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_rw[d]    = rw;
        req_size[d]  = size;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid[d]) begin
                lat   = k;
                rdata = resp_rdata[d];
                err   = resp_err[d];
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            check("pulse_end", 32'(resp_valid[d]), 32'd0);
            check("rdata_clear", resp_rdata[d], 32'd0);
        end
    endtask

    task automatic run_vec(input int d, input string tag, input vec_t v);
        logic [31:0] r;
        logic        e;
        int          l;
        logic [31:0] mr;
        logic        me;
        int          ml;
        model_req(d, v.rw, v.size, v.addr, v.wdata, mr, me, ml);
        do_req(d, v.rw, v.size, v.addr, v.wdata, r, e, l);
        check({tag, "_rdata"}, r, v.rdata);
        check({tag, "_err"}, 32'(e), 32'(v.err));
        check({tag, "_lat"}, 32'(l), 32'(v.lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        vec_t        v;
        logic [31:0] r, mr;
        logic        e, me;
        int          l, ml;
        int          resp_cnt;

        for (int d = 0; d < 2; d++) begin
            R[d] = 1'b0; req_valid[d] = 1'b0; req_rw[d] = 1'b0;
            req_size[d] = 1'b0; req_addr[d] = 8'h0; req_wdata[d] = 32'h0;
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) poke(d, 8'(i), 8'($urandom));
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd1);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", resp_rdata[d], 32'd0);
            check("rst_err", 32'(resp_err[d]), 32'd0);
        end
        R[0] = 1'b1;
        R[1] = 1'b1;

        // Directed table on the WAIT_CYCLES=1 instance.
        tbl[0] = '{1'b1, 1'b0, 8'h10, 32'h000000A5, 32'h0,          1'b0, 2};
        tbl[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'h000000A5,   1'b0, 2};
        tbl[2] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'h0,          1'b0, 5};
        tbl[3] = '{1'b0, 1'b0, 8'h20, 32'h0,        32'h00000012,   1'b0, 2};
        tbl[4] = '{1'b0, 1'b0, 8'h23, 32'h0,        32'h00000078,   1'b0, 2};
        tbl[5] = '{1'b0, 1'b1, 8'h20, 32'h0,        32'h12345678,   1'b0, 5};
        tbl[6] = '{1'b0, 1'b1, 8'h21, 32'h0,        32'h0,          1'b1, 1};
        tbl[7] = '{1'b1, 1'b1, 8'h22, 32'hCAFEF00D, 32'h0,          1'b1, 1};
        tbl[8] = '{1'b0, 1'b1, 8'h20, 32'h0,        32'h12345678,   1'b0, 5};
        tbl[9] = '{1'b0, 1'b0, 8'h22, 32'h0,        32'h00000056,   1'b0, 2};
        for (int i = 0; i < 10; i++) run_vec(1, $sformatf("tbl%0d", i), tbl[i]);

        // WAIT_CYCLES=0 boundary address and zero-wait latencies.
        run_vec(0, "w0_st_ff", '{1'b1, 1'b0, 8'hFF, 32'hFFFFFF3C, 32'h0,        1'b0, 1});
        run_vec(0, "w0_ld_ff", '{1'b0, 1'b0, 8'hFF, 32'h0,        32'h0000003C, 1'b0, 1});
        run_vec(0, "w0_st_w",  '{1'b1, 1'b1, 8'hF0, 32'hA1B2C3D4, 32'h0,        1'b0, 4});
        run_vec(0, "w0_ld_w",  '{1'b0, 1'b1, 8'hF0, 32'h0,        32'hA1B2C3D4, 1'b0, 4});
        run_vec(0, "w0_mis",   '{1'b0, 1'b1, 8'hF3, 32'h0,        32'h0,        1'b1, 1});

        // Held req_valid with back-to-back requests: A = word store, B = word load.
        @(negedge clk);
        req_valid[1] = 1'b1; req_rw[1] = 1'b1; req_size[1] = 1'b1;
        req_addr[1] = 8'h30; req_wdata[1] = 32'h11223344;
        model_req(1, 1'b1, 1'b1, 8'h30, 32'h11223344, mr, me, ml);
        resp_cnt = 0;
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                req_rw[1] = 1'b0; req_addr[1] = 8'h30; req_wdata[1] = 32'h0;
            end
            if (k == 7) req_valid[1] = 1'b0;
            check($sformatf("hs_ready_e%0d", k), 32'(req_ready[1]), 32'(k == 6 || k == 13));
            check($sformatf("hs_busy_e%0d", k), 32'(busy[1]), 32'(!(k == 6 || k == 13)));
            check($sformatf("hs_valid_e%0d", k), 32'(resp_valid[1]), 32'(k == 5 || k == 12));
            if (resp_valid[1]) resp_cnt++;
            if (k == 12) check("hs_rdata_b", resp_rdata[1], 32'h11223344);
        end
        check("hs_resp_count", 32'(resp_cnt), 32'd2);
        model_req(1, 1'b0, 1'b1, 8'h30, 32'h0, mr, me, ml);

        // Reset after beat 1 of a word store: only the first two bytes land.
        for (int i = 0; i < 4; i++) poke(1, 8'h40 + 8'(i), 8'h00);
        @(negedge clk);
        req_valid[1] = 1'b1; req_rw[1] = 1'b1; req_size[1] = 1'b1;
        req_addr[1] = 8'h40; req_wdata[1] = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        resp_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp_valid[1]) resp_cnt++;
        end
        R[1] = 1'b0;
        @(posedge clk);
        #1;
        check("rst_abort_ready", 32'(req_ready[1]), 32'd1);
        check("rst_abort_valid", 32'(resp_valid[1]), 32'd0);
        R[1] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp_valid[1]) resp_cnt++;
        end
        check("rst_abort_no_resp", 32'(resp_cnt), 32'd0);
        check("rst_abort_m40", 32'(peek(1, 8'h40)), 32'hDE);
        check("rst_abort_m41", 32'(peek(1, 8'h41)), 32'hAD);
        check("rst_abort_m42", 32'(peek(1, 8'h42)), 32'h00);
        check("rst_abort_m43", 32'(peek(1, 8'h43)), 32'h00);
        model[1][8'h40] = 8'hDE;
        model[1][8'h41] = 8'hAD;

        // Random traffic against the byte-array model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                v.rw    = 1'($urandom);
                v.size  = 1'($urandom);
                v.addr  = ($urandom % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
                if (v.size && ($urandom % 4 != 0)) v.addr[1:0] = 2'b00;
                v.wdata = $urandom;
                model_req(d, v.rw, v.size, v.addr, v.wdata, mr, me, ml);
                do_req(d, v.rw, v.size, v.addr, v.wdata, r, e, l);
                check($sformatf("rnd%0d_%0d_rdata", d, i), r, mr);
                check($sformatf("rnd%0d_%0d_err", d, i), 32'(e), 32'(me));
                check($sformatf("rnd%0d_%0d_lat", d, i), 32'(l), 32'(ml));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
